// File: rtl/plic_axil_slave.sv
// AXI4-Lite slave that turns AXI write/read transactions into single-cycle accesses on the
// interrupt controller's simple register port (waddr/wdata/wstrb/wen, raddr/rdata).
module plic_axil_slave #(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_LIMIT = 16'h1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [ADDR_WIDTH-1:0]     reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
  output logic                      reg_wen,
  output logic [ADDR_WIDTH-1:0]     reg_raddr,
  input  logic [DATA_WIDTH-1:0]     reg_rdata
);

  typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_RESP} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_SAMPLE, R_RESP} rState_t;

  wState_t                  r_wState;
  rState_t                  r_rState;
  logic                     r_awFull;
  logic                     r_wFull;
  logic [ADDR_WIDTH-1:0]    r_awAddr;
  logic [DATA_WIDTH-1:0]    r_wData;
  logic [DATA_WIDTH/8-1:0]  r_wStrb;

  logic                     w_awHs;
  logic                     w_wHs;
  logic                     w_arHs;
  logic                     w_awCaptured;
  logic                     w_wCaptured;
  logic [ADDR_WIDTH-1:0]    w_awAddrSel;
  logic [DATA_WIDTH-1:0]    w_wDataSel;
  logic [DATA_WIDTH/8-1:0]  w_wStrbSel;

  assign w_awHs       = s_awvalid & s_awready;
  assign w_wHs        = s_wvalid & s_wready;
  assign w_arHs       = s_arvalid & s_arready;
  assign w_awCaptured = r_awFull | w_awHs;
  assign w_wCaptured  = r_wFull | w_wHs;

  // A beat arriving this cycle bypasses its buffer so exec can start right after the last handshake.
  assign w_awAddrSel  = r_awFull ? r_awAddr : s_awaddr;
  assign w_wDataSel   = r_wFull  ? r_wData  : s_wdata;
  assign w_wStrbSel   = r_wFull  ? r_wStrb  : s_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wState  <= W_COLLECT;
      r_awFull  <= 1'b0;
      r_wFull   <= 1'b0;
      r_awAddr  <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      reg_waddr <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      reg_wen   <= 1'b0;
    end else begin
      unique case (r_wState)
        W_COLLECT: begin
          if (w_awHs) begin
            r_awFull <= 1'b1;
            r_awAddr <= s_awaddr;
          end
          if (w_wHs) begin
            r_wFull <= 1'b1;
            r_wData <= s_wdata;
            r_wStrb <= s_wstrb;
          end
          if (w_awCaptured && w_wCaptured) begin
            reg_waddr <= w_awAddrSel;
            reg_wdata <= w_wDataSel;
            reg_wstrb <= w_wStrbSel;
            reg_wen   <= (w_awAddrSel < ADDR_LIMIT) && (w_wStrbSel != '0);
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            r_wState  <= W_EXEC;
          end else begin
            s_awready <= !w_awCaptured;
            s_wready  <= !w_wCaptured;
          end
        end
        W_EXEC: begin
          reg_wen  <= 1'b0;
          s_bvalid <= 1'b1;
          s_bresp  <= (reg_waddr >= ADDR_LIMIT) ? 2'b10 : 2'b00;
          r_wState <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            r_awFull  <= 1'b0;
            r_wFull   <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            r_wState  <= W_COLLECT;
          end
        end
        default: r_wState <= W_COLLECT;
      endcase
    end
  end

  // Read data is taken one cycle after the address lands on reg_raddr, giving the register file a full cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rState  <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
      reg_raddr <= '0;
    end else begin
      unique case (r_rState)
        R_IDLE: begin
          if (w_arHs) begin
            reg_raddr <= s_araddr;
            s_arready <= 1'b0;
            r_rState  <= R_SAMPLE;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_SAMPLE: begin
          if (reg_raddr >= ADDR_LIMIT) begin
            s_rdata <= '0;
            s_rresp <= 2'b10;
          end else begin
            s_rdata <= reg_rdata;
            s_rresp <= 2'b00;
          end
          s_rvalid <= 1'b1;
          r_rState <= R_RESP;
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_rState  <= R_IDLE;
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

endmodule
